// File: rtl/sisc_ctrl_mc.sv
// Multicycle control FSM for the SISC datapath: variable-length sequencing,
// HALT state, optional data-memory handshake with timeout, retired counter.
module sisc_ctrl_mc #(
  parameter int OP_W     = 4,
  parameter int CC_W     = 4,
  parameter int IMM_MODE = 8,
  parameter int MEM_WAIT = 0,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [OP_W-1:0]  opcode,
  input  logic [CC_W-1:0]  mm,
  input  logic [CC_W-1:0]  stat,
  input  logic             dm_ack,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             rb_sel,
  output logic             pc_sel,
  output logic             pc_write,
  output logic             pc_rst,
  output logic             ir_load,
  output logic             br_sel,
  output logic             mux_16_sel,
  output logic             dm_we,
  output logic             dm_re,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);
  localparam logic [CC_W-1:0] IMM_V  = CC_W'(IMM_MODE);

  localparam int              WC_W      = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;

  logic is_lod, is_str, is_alu, is_hlt, is_bra, is_brr, is_bne, is_bnr, is_br;
  logic cond, br_taken, imm, mem_done, retire, timeout;

  assign is_lod   = (opcode == OP_LOD);
  assign is_str   = (opcode == OP_STR);
  assign is_alu   = (opcode == OP_ALU);
  assign is_hlt   = (opcode == OP_HLT);
  assign is_bra   = (opcode == OP_BRA);
  assign is_brr   = (opcode == OP_BRR);
  assign is_bne   = (opcode == OP_BNE);
  assign is_bnr   = (opcode == OP_BNR);
  assign is_br    = is_bra | is_brr | is_bne | is_bnr;
  assign cond     = |(stat & mm);
  assign br_taken = ((is_bra | is_brr) & cond) | ((is_bne | is_bnr) & ~cond);
  assign imm      = (mm == IMM_V);
  // Without the handshake MEM always completes in its single cycle.
  assign mem_done = (MEM_WAIT == 0) || dm_ack;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q   <= S_RST;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (is_hlt)                           state_d = S_HALT;
        else if (is_lod || is_str || is_alu)  state_d = S_EXECUTE;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: state_d = is_alu ? S_WB : S_MEM;
      S_MEM: begin
        // An ack arriving on the last allowed cycle still completes the access.
        if (mem_done) begin
          if (is_str) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          timeout = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RST;
    endcase

    wait_d    = (state_q == S_MEM && state_d == S_MEM) ? wait_q + WC_W'(1) : '0;
    retired_d = retired_q + CNT_W'(retire);
    err_d     = err_q | timeout;
  end

  always_comb begin
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    rb_sel     = 1'b0;
    pc_sel     = 1'b0;
    pc_write   = 1'b0;
    pc_rst     = 1'b0;
    ir_load    = 1'b0;
    br_sel     = 1'b0;
    mux_16_sel = 1'b0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    alu_op     = 2'b00;
    halted     = 1'b0;
    unique case (state_q)
      S_RST:   pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        pc_sel   = is_br;
        pc_write = is_br & br_taken;
        br_sel   = is_bra | is_bne;
      end
      S_EXECUTE: begin
        if (is_alu) alu_op = {1'b0, imm};
        else        alu_op = {1'b1, imm};
      end
      S_MEM: begin
        mux_16_sel = imm;
        dm_we      = is_str;
        dm_re      = is_lod;
        wb_sel     = is_lod;
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = is_lod;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed bench for sisc_ctrl_mc: a handshake instance (MEM_WAIT=1, CNT_W=4)
// and a fixed-MEM instance (MEM_WAIT=0) sharing the same stimulus.
module tb_sisc_ctrl_mc;
  logic       clk = 1'b0;
  logic       rst_f = 1'b1;
  logic [3:0] opcode = '0, mm = '0, stat = '0;
  logic       dm_ack = 1'b0;

  logic       rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel;
  logic       mux_16_sel, dm_we, dm_re, halted, err;
  logic [1:0] alu_op;
  logic [3:0] retired;

  logic        rf_we0, wb_sel0, rb_sel0, pc_sel0, pc_write0, pc_rst0, ir_load0, br_sel0;
  logic        mux_16_sel0, dm_we0, dm_re0, halted0, err0;
  logic [1:0]  alu_op0;
  logic [15:0] retired0;

  logic [13:0] ctl, ctl0;
  assign ctl  = {rf_we, wb_sel, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel,
                 mux_16_sel, dm_we, dm_re, alu_op, halted};
  assign ctl0 = {rf_we0, wb_sel0, rb_sel0, pc_sel0, pc_write0, pc_rst0, ir_load0, br_sel0,
                 mux_16_sel0, dm_we0, dm_re0, alu_op0, halted0};

  localparam logic [13:0] C_RF  = 14'h2000, C_WB  = 14'h1000, C_PCS = 14'h0400;
  localparam logic [13:0] C_PCW = 14'h0200, C_PCR = 14'h0100, C_IR  = 14'h0080;
  localparam logic [13:0] C_BR  = 14'h0040, C_MX  = 14'h0020, C_WE  = 14'h0010;
  localparam logic [13:0] C_RE  = 14'h0008, C_A1  = 14'h0004, C_A0  = 14'h0002;
  localparam logic [13:0] C_H   = 14'h0001;

  sisc_ctrl_mc #(.MEM_WAIT(1), .WAIT_MAX(15), .CNT_W(4)) u_dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .dm_ack(dm_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel), .pc_sel(pc_sel), .pc_write(pc_write),
    .pc_rst(pc_rst), .ir_load(ir_load), .br_sel(br_sel), .mux_16_sel(mux_16_sel),
    .dm_we(dm_we), .dm_re(dm_re), .alu_op(alu_op), .halted(halted), .err(err),
    .retired(retired)
  );

  sisc_ctrl_mc #(.MEM_WAIT(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .dm_ack(dm_ack),
    .rf_we(rf_we0), .wb_sel(wb_sel0), .rb_sel(rb_sel0), .pc_sel(pc_sel0),
    .pc_write(pc_write0), .pc_rst(pc_rst0), .ir_load(ir_load0), .br_sel(br_sel0),
    .mux_16_sel(mux_16_sel0), .dm_we(dm_we0), .dm_re(dm_re0), .alu_op(alu_op0),
    .halted(halted0), .err(err0), .retired(retired0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current state's controls, then advance one clock.
  task automatic step(input string tag, input logic [13:0] exp);
    #1 chk(tag, {18'd0, ctl}, {18'd0, exp});
    @(negedge clk);
  endtask

  task automatic step_nobr(input string tag, input logic [13:0] exp);
    #1 chk(tag, {18'd0, ctl & ~C_BR}, {18'd0, exp});
    @(negedge clk);
  endtask

  task automatic step0(input string tag, input logic [13:0] exp);
    #1 chk(tag, {18'd0, ctl0}, {18'd0, exp});
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1 chk("rst_ctl", {18'd0, ctl}, {18'd0, C_PCR});
    chk("rst_retired", retired, 0);
    chk("rst_err", err, 0);
    rst_f = 1'b0;
    step("rst_release", C_PCR);

    // Four NOOPs
    opcode = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step("noop_fetch", C_IR | C_PCW);
      step("noop_decode", 14'h0);
    end
    chk("noop_retired", retired, 4);

    // ALU immediate then register
    opcode = 4'd8; mm = 4'd8;
    step("alu_fetch", C_IR | C_PCW);
    step("alu_decode", 14'h0);
    step("alu_exec_imm", C_A0);
    step("alu_wb", C_RF);
    mm = 4'd0;
    step("alu_fetch2", C_IR | C_PCW);
    step("alu_decode2", 14'h0);
    step("alu_exec_reg", 14'h0);
    step("alu_wb2", C_RF);
    chk("alu_retired", retired, 6);

    // Branches with stat=0100
    stat = 4'b0100;
    opcode = 4'd4; mm = 4'b0100;
    step("bra_fetch", C_IR | C_PCW);
    step("bra_taken", C_PCS | C_PCW | C_BR);
    opcode = 4'd6; mm = 4'b0100;
    step("bne_fetch", C_IR | C_PCW);
    step_nobr("bne_not_taken", C_PCS);
    opcode = 4'd7; mm = 4'b0010;
    step("bnr_fetch", C_IR | C_PCW);
    step("bnr_taken", C_PCS | C_PCW);
    opcode = 4'd5; mm = 4'b0001;
    step("brr_fetch", C_IR | C_PCW);
    step("brr_not_taken", C_PCS);
    chk("br_retired", retired, 10);

    // STR with ack in the first MEM cycle: both instances agree
    opcode = 4'd2; mm = 4'd0; dm_ack = 1'b1;
    step("str_fetch", C_IR | C_PCW);
    step("str_decode", 14'h0);
    step("str_exec", C_A1);
    step("str_mem", C_WE);
    dm_ack = 1'b0;
    chk("str_retired", retired, 11);
    chk("str_retired0", retired0, 11);

    // LOD immediate, ack on the third MEM cycle
    opcode = 4'd1; mm = 4'd8;
    step("lod_fetch", C_IR | C_PCW);
    step("lod_decode", 14'h0);
    step("lod_exec", C_A1 | C_A0);
    step("lod_mem1", C_MX | C_RE | C_WB);
    step("lod_mem2", C_MX | C_RE | C_WB);
    dm_ack = 1'b1;
    step("lod_mem3", C_MX | C_RE | C_WB);
    dm_ack = 1'b0;
    step("lod_wb", C_RF | C_WB);
    chk("lod_retired", retired, 12);

    // STR with no ack: timeout after 15 MEM cycles
    opcode = 4'd2; mm = 4'd0;
    step("sto_fetch", C_IR | C_PCW);
    step("sto_decode", 14'h0);
    step("sto_exec", C_A1);
    for (int i = 0; i < 15; i++) step("sto_wait", C_WE);
    step("sto_halt", C_H);
    chk("sto_err", err, 1);
    chk("sto_retired", retired, 12);

    // Reset from HALT, then NOOP + HLT
    pulse_rst();
    #1 chk("rst2_err", err, 0);
    chk("rst2_retired", retired, 0);
    opcode = 4'd0;
    step("rst2_state", C_PCR);
    step("h_noop_fetch", C_IR | C_PCW);
    step("h_noop_decode", 14'h0);
    opcode = 4'd15;
    step("hlt_fetch", C_IR | C_PCW);
    step("hlt_decode", 14'h0);
    opcode = 4'd2; mm = 4'd8; stat = 4'hF; dm_ack = 1'b1;
    for (int i = 0; i < 3; i++) step("hlt_frozen", C_H);
    dm_ack = 1'b0; stat = 4'b0100;
    chk("hlt_retired", retired, 1);
    chk("hlt_err", err, 0);

    // Reset during a MEM wait, then 17 NOOPs wrap the 4-bit counter
    pulse_rst();
    opcode = 4'd1; mm = 4'd8;
    step("mr_rst", C_PCR);
    step("mr_fetch", C_IR | C_PCW);
    step("mr_decode", 14'h0);
    step("mr_exec", C_A1 | C_A0);
    rst_f = 1'b1;
    step("mr_mem", C_MX | C_RE | C_WB);
    rst_f = 1'b0;
    opcode = 4'd0; mm = 4'd0;
    step("mr_back_rst", C_PCR);
    for (int i = 0; i < 17; i++) begin
      step("wrap_fetch", C_IR | C_PCW);
      step("wrap_decode", 14'h0);
    end
    chk("wrap_retired", retired, 1);

    // Fixed one-cycle MEM instance: LOD without any ack
    pulse_rst();
    opcode = 4'd1; mm = 4'd0; dm_ack = 1'b0;
    step0("m0_rst", C_PCR);
    step0("m0_fetch", C_IR | C_PCW);
    step0("m0_decode", 14'h0);
    step0("m0_exec", C_A1);
    step0("m0_mem", C_RE | C_WB);
    step0("m0_wb", C_RF | C_WB);
    #1 chk("m0_retired", retired0, 1);
    chk("m0_fetch_again", {18'd0, ctl0}, {18'd0, C_IR | C_PCW});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
